// File: rtl/definitions.sv
// Shared control-path types and constants for the accumulator core:
// ALU opcodes, the decoded control bundle, sequencer states and instruction classes.
package definitions;

  localparam logic [3:0] kPASS_A   = 4'd0;
  localparam logic [3:0] kADD      = 4'd1;
  localparam logic [3:0] kSUB      = 4'd2;
  localparam logic [3:0] kAND      = 4'd3;
  localparam logic [3:0] kOR       = 4'd4;
  localparam logic [3:0] kXOR      = 4'd5;
  localparam logic [3:0] kNOT_A    = 4'd6;
  localparam logic [3:0] kSHIFT_L  = 4'd7;
  localparam logic [3:0] kSHIFT_R  = 4'd8;
  localparam logic [3:0] kSHIFT_ON = 4'd9;

  // Top-seven-bit opcodes of the non-ALU instructions (ALU class is MSB = 0).
  localparam logic [6:0] OP_LOAD   = 7'b1000000;
  localparam logic [6:0] OP_STORE  = 7'b1000001;
  localparam logic [6:0] OP_BOZ    = 7'b1000010;
  localparam logic [6:0] OP_BZ     = 7'b1000011;
  localparam logic [6:0] OP_SHL    = 7'b1000100;
  localparam logic [6:0] OP_SHR    = 7'b1000101;
  localparam logic [6:0] OP_SHON   = 7'b1000110;
  localparam logic [6:0] OP_MOVR   = 7'b1001000;

  typedef struct packed {
    logic       Format;
    logic       AccRead;
    logic [1:0] RegWrite;
    logic       Branch;
    logic [1:0] ALUSrcB;
    logic       MemWrite;
    logic [1:0] MemtoReg;
    logic [3:0] ALUOp;
    logic       OverflowSwitch;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{Format: 1'b1, AccRead: 1'b0, RegWrite: 2'd0,
                                   Branch: 1'b0, ALUSrcB: 2'd0, MemWrite: 1'b0,
                                   MemtoReg: 2'd0, ALUOp: kPASS_A, OverflowSwitch: 1'b0};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } seq_state_t;

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    STORE   = 3'd1,
    ALU     = 3'd2,
    BRANCH  = 3'd3,
    ILLEGAL = 3'd4
  } insn_class_t;

endpackage

// File: rtl/insn_decode.sv
// Purely combinational instruction decoder shared by the multi-cycle sequencer
// and the single-cycle core; unknown opcodes raise the halt flag.
module insn_decode
  import definitions::*;
#(
  parameter int IW = 9
) (
  input  logic [IW-1:0] ir,
  output ctrl_t         ctrl,
  output insn_class_t   cls,
  output logic          halt
);

  logic [6:0] opc;
  logic       unused_operand;

  assign opc            = ir[IW-1:IW-7];
  assign unused_operand = ^ir[IW-8:0];

  // Opcode to control-bundle mapping; anything not listed is illegal.
  always_comb begin
    ctrl = CTRL_RESET;
    cls  = ILLEGAL;
    halt = 1'b1;
    if (opc[6] == 1'b0) begin
      // Accumulator ALU ops: operation in bits [5:4], immediate select in bit 3.
      ctrl.AccRead  = 1'b1;
      ctrl.RegWrite = 2'd2;
      ctrl.ALUSrcB  = {1'b0, opc[3]};
      ctrl.ALUOp    = {2'b00, opc[5:4]};
      cls           = ALU;
      halt          = 1'b0;
    end else begin
      case (opc)
        OP_LOAD: begin
          ctrl.Format = 1'b0; ctrl.RegWrite = 2'd1; ctrl.MemtoReg = 2'd1;
          ctrl.ALUSrcB = 2'd2; ctrl.ALUOp = kADD; cls = LOAD; halt = 1'b0;
        end
        OP_STORE: begin
          ctrl.Format = 1'b0; ctrl.AccRead = 1'b1; ctrl.MemWrite = 1'b1;
          ctrl.ALUSrcB = 2'd2; ctrl.ALUOp = kADD; cls = STORE; halt = 1'b0;
        end
        OP_BOZ, OP_BZ: begin
          ctrl.Format = 1'b0; ctrl.Branch = 1'b1; ctrl.OverflowSwitch = (opc == OP_BOZ);
          cls = BRANCH; halt = 1'b0;
        end
        OP_SHL, OP_SHR, OP_SHON: begin
          ctrl.Format = 1'b0; ctrl.AccRead = 1'b1; ctrl.RegWrite = 2'd2;
          ctrl.ALUOp = (opc == OP_SHL) ? kSHIFT_L : ((opc == OP_SHR) ? kSHIFT_R : kSHIFT_ON);
          cls = ALU; halt = 1'b0;
        end
        OP_MOVR: begin
          ctrl.Format = 1'b0; ctrl.AccRead = 1'b1; ctrl.RegWrite = 2'd1;
          ctrl.ALUOp = kPASS_A; cls = ALU; halt = 1'b0;
        end
        default: begin
          cls  = ILLEGAL;
          halt = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with req/ack memory
// handshakes, data-memory timeout fault and a saturating retired counter.
module ctrl_sequencer
  import definitions::*;
#(
  parameter int IW          = 9,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [IW-1:0]    imem_rdata,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic [IW-1:0]    ir,
  output ctrl_t            ctrl,
  output logic             reg_we,
  output logic             pc_en,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  seq_state_t  state, state_nxt;
  insn_class_t cls, dec_cls;
  ctrl_t       dec_ctrl;
  logic        dec_halt;
  logic [7:0]  wait_cnt;
  logic        mem_timeout;

  insn_decode #(.IW(IW)) u_decode (
    .ir   (ir),
    .ctrl (dec_ctrl),
    .cls  (dec_cls),
    .halt (dec_halt)
  );

  // An ack on the last allowed wait cycle still wins over the timeout.
  assign mem_timeout = (wait_cnt == TIMEOUT) && !dmem_ack;

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = start ? S_FETCH : S_IDLE;
      S_FETCH:  state_nxt = imem_ack ? S_DECODE : S_FETCH;
      S_DECODE: state_nxt = dec_halt ? S_HALT : S_EXEC;
      S_EXEC:   state_nxt = (cls == LOAD || cls == STORE) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) begin
          state_nxt = S_WB;
        end else if (mem_timeout) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_MEM;
        end
      end
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State, datapath-facing registers and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cls      <= ALU;
      wait_cnt <= 8'd0;
      ir       <= {IW{1'b0}};
      ctrl     <= CTRL_RESET;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      reg_we   <= 1'b0;
      pc_en    <= 1'b0;
      halted   <= 1'b0;
      fault    <= 1'b0;
      retired  <= {CNT_W{1'b0}};
    end else begin
      state    <= state_nxt;
      imem_req <= (state_nxt == S_FETCH);
      dmem_req <= (state_nxt == S_MEM);
      pc_en    <= (state_nxt == S_WB);
      reg_we   <= (state_nxt == S_WB) && (ctrl.RegWrite == 2'd1);
      halted   <= (state_nxt == S_HALT);
      fault    <= fault | ((state == S_MEM) && mem_timeout);
      wait_cnt <= ((state == S_MEM) && (state_nxt == S_MEM)) ? wait_cnt + 8'd1 : 8'd0;
      if ((state == S_FETCH) && imem_ack) begin
        ir <= imem_rdata;
      end
      if (state == S_DECODE) begin
        ctrl <= dec_ctrl;
        cls  <= dec_cls;
      end
      if ((state_nxt == S_WB) && (retired != CNT_MAX)) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomised self-checking bench for ctrl_sequencer: a transaction-level model
// predicts per-phase strobes, control fields, halt/fault and the retired count.
module tb_ctrl_sequencer;
  import definitions::*;

  localparam int IW      = 9;
  localparam int TO      = 15;
  localparam int CW      = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic       legal;
    logic       mem;
    logic       memwrite;
    logic       branch;
    logic [1:0] regwrite;
    logic [1:0] memtoreg;
  } info_t;

  logic          clk = 1'b0;
  logic          reset, start, imem_ack, dmem_ack;
  logic [IW-1:0] imem_rdata;
  logic          imem_req, dmem_req, reg_we, pc_en, halted, fault;
  logic [IW-1:0] ir;
  ctrl_t         ctrl;
  logic [CW-1:0] retired;

  int errors = 0;
  int checks = 0;
  int exp_retired = 0;
  int exp_fault = 0;
  int st;

  always #5 clk = ~clk;

  ctrl_sequencer #(.IW(IW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .ir(ir), .ctrl(ctrl), .reg_we(reg_we), .pc_en(pc_en),
    .halted(halted), .fault(fault), .retired(retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ISA table: what each opcode is supposed to do.
  function automatic info_t classify(input logic [6:0] opc);
    info_t i;
    i = '0;
    i.legal = 1'b1;
    if (opc[6] == 1'b0) i.regwrite = 2'd2;
    else if (opc == 7'b1000000) begin i.mem = 1'b1; i.regwrite = 2'd1; i.memtoreg = 2'd1; end
    else if (opc == 7'b1000001) begin i.mem = 1'b1; i.memwrite = 1'b1; end
    else if (opc == 7'b1000010 || opc == 7'b1000011) i.branch = 1'b1;
    else if (opc == 7'b1000100 || opc == 7'b1000101 || opc == 7'b1000110) i.regwrite = 2'd2;
    else if (opc == 7'b1001000) i.regwrite = 2'd1;
    else i.legal = 1'b0;
    return i;
  endfunction

  function automatic logic [IW-1:0] gen_insn();
    int r;
    logic [6:0] opc;
    r = $urandom_range(0, 99);
    if (r < 40)      opc = {1'b0, 6'($urandom)};
    else if (r < 60) opc = 7'b1000000;
    else if (r < 75) opc = 7'b1000001;
    else if (r < 85) opc = {5'b10000, 2'($urandom)};
    else if (r < 92) opc = {5'b10001, 2'($urandom)};
    else             opc = 7'($urandom);
    return {opc, 2'($urandom)};
  endfunction

  function automatic logic coin(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_imem_req"}, 32'(imem_req), 32'(0));
    check({tag, "_dmem_req"}, 32'(dmem_req), 32'(0));
    check({tag, "_strobes"}, 32'({reg_we, pc_en}), 32'(0));
    check({tag, "_halt_fault"}, 32'({halted, fault}), 32'(0));
    check({tag, "_retired"}, 32'(retired), 32'(0));
    check({tag, "_ir"}, 32'(ir), 32'(0));
    check({tag, "_ctrl"}, 32'(ctrl), 32'(CTRL_RESET));
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;
    exp_retired = 0;
    exp_fault = 0;
    @(negedge clk);
    check("idle_no_start", 32'(imem_req), 32'(0));
    start = 1'b1;
    @(negedge clk);
    start = coin(30);
  endtask

  // Drives one instruction through all phases; status 0 retired, 1 halted, 2 reset in MEM.
  task automatic run_insn(input logic [IW-1:0] insn, input int fd, input int md,
                          input int rst_at, output int status);
    info_t inf;
    int last;
    inf = classify(insn[IW-1:IW-7]);
    for (int k = 0; k <= fd; k++) begin
      check("fetch_req", 32'(imem_req), 32'(1));
      check("fetch_quiet", 32'({dmem_req, pc_en, reg_we}), 32'(0));
      imem_ack   = (k == fd);
      imem_rdata = (k == fd) ? insn : IW'($urandom);
      dmem_ack   = coin(30);
      @(negedge clk);
    end
    check("decode_ir", 32'(ir), 32'(insn));
    check("decode_quiet", 32'({imem_req, dmem_req, pc_en}), 32'(0));
    imem_ack = coin(30); imem_rdata = IW'($urandom); dmem_ack = coin(30);
    @(negedge clk);
    if (!inf.legal) begin
      exp_fault = 0;
      check("illegal_halt", 32'({halted, fault}), 32'(2'b10));
      check("illegal_retired", 32'(retired), 32'(exp_retired));
      check("illegal_quiet", 32'({pc_en, reg_we, imem_req}), 32'(0));
      status = 1;
      return;
    end
    check("exec_halted", 32'(halted), 32'(0));
    check("exec_quiet", 32'({pc_en, reg_we, dmem_req}), 32'(0));
    check("exec_ctrl", 32'({ctrl.RegWrite, ctrl.MemtoReg, ctrl.MemWrite, ctrl.Branch}),
          32'({inf.regwrite, inf.memtoreg, inf.memwrite, inf.branch}));
    imem_ack = coin(30); dmem_ack = coin(30);
    @(negedge clk);
    if (inf.mem) begin
      last = (md > TO) ? TO : md;
      for (int w = 0; w <= last; w++) begin
        check("mem_req", 32'(dmem_req), 32'(1));
        check("mem_quiet", 32'({pc_en, imem_req}), 32'(0));
        if (w == rst_at) begin
          reset = 1'b1; dmem_ack = 1'b0; imem_ack = 1'b0;
          @(negedge clk);
          check_reset_values("mem_rst");
          reset = 1'b0;
          exp_retired = 0;
          status = 2;
          return;
        end
        dmem_ack = (w == md);
        imem_ack = coin(30);
        @(negedge clk);
      end
      dmem_ack = 1'b0;
      if (md > TO) begin
        exp_fault = 1;
        check("timeout_halt", 32'({halted, fault}), 32'(2'b11));
        check("timeout_req_drop", 32'({dmem_req, pc_en}), 32'(0));
        check("timeout_retired", 32'(retired), 32'(exp_retired));
        status = 1;
        return;
      end
    end
    exp_retired = (exp_retired + 1 > CNT_MAX) ? CNT_MAX : exp_retired + 1;
    check("wb_pc_en", 32'(pc_en), 32'(1));
    check("wb_reg_we", 32'(reg_we), 32'(inf.regwrite == 2'd1));
    check("wb_retired", 32'(retired), 32'(exp_retired));
    check("wb_quiet", 32'({dmem_req, imem_req, halted}), 32'(0));
    imem_ack = coin(30); imem_rdata = IW'($urandom); dmem_ack = coin(30);
    @(negedge clk);
    status = 0;
  endtask

  task automatic hold_halt(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      start = coin(50); imem_ack = coin(50); dmem_ack = coin(50);
      @(negedge clk);
      check("halt_sticky", 32'({halted, fault}), 32'({1'b1, exp_fault[0]}));
      check("halt_quiet", 32'({imem_req, dmem_req, pc_en, reg_we}), 32'(0));
      check("halt_retired", 32'(retired), 32'(exp_retired));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0;

    // Directed scenarios from the bring-up plan.
    do_reset();
    run_insn(9'b001_000101, 3, 0, -1, st);
    check("add_aluop", 32'(ctrl.ALUOp), 32'(kADD));
    run_insn(9'b1000000_01, 0, 2, -1, st);
    run_insn(9'b1000001_00, 1, 99, -1, st);
    check("store_timeout_status", 32'(st), 32'(1));
    hold_halt(6);

    do_reset();
    run_insn(9'b111111111, 0, 0, -1, st);
    check("illegal_status", 32'(st), 32'(1));
    hold_halt(4);

    do_reset();
    run_insn(9'b1000000_01, 0, 5, 2, st);
    check("mem_reset_status", 32'(st), 32'(2));

    do_reset();
    for (int n = 0; n < 9; n++) run_insn(9'b1000010_00, n % 2, 0, -1, st);
    run_insn(9'b1000001_11, 0, TO, -1, st);
    check("ack_at_timeout_status", 32'(st), 32'(0));

    // Random episodes.
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      for (int n = 0; n < 12; n++) begin
        int r, md, rst_at;
        r = $urandom_range(0, 99);
        if (r < 70)      md = $urandom_range(0, 3);
        else if (r < 85) md = $urandom_range(4, TO - 1);
        else if (r < 92) md = TO;
        else             md = $urandom_range(TO + 1, TO + 5);
        rst_at = coin(5) ? $urandom_range(0, 3) : -1;
        run_insn(gen_insn(), $urandom_range(0, 3), md, rst_at, st);
        if (st == 1) hold_halt(3);
        if (st != 0) break;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
